display_frame_scheduler: RTL

Sequences the double-buffered display's back-buffer port (port b of `display_buffer_mux`) across a fixed per-frame cycle: clear, draw, wait for vertical blank, swap. It sits between the VGA timing generator, a single pixel-drawing client and the buffer mux. It owns the mux's port-b write controls and its `frame_complete` swap strobe, so buffer swaps only happen on a vertical-blank boundary after the client has finished its frame.

---
 rtl/display_frame_scheduler_pkg.sv | 23 ++
 rtl/display_frame_scheduler_if.sv | 34 +++
 rtl/raster_counter.sv | 35 +++
 rtl/display_frame_scheduler.sv | 139 +++++++++++++
 4 files changed

// File: rtl/display_frame_scheduler_pkg.sv
// Shared display types: pixel format, default raster size and the
// per-frame scheduler state encoding.
package display_frame_scheduler_pkg;

  localparam int DISPLAY_H_ACTIVE = 640;
  localparam int DISPLAY_V_ACTIVE = 480;

  typedef logic [11:0] pixel_t;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_DRAW,
    ST_WAIT_VBLANK,
    ST_SWAP
  } frame_sched_state_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/display_frame_scheduler_if.sv
// Pixel-drawing client handshake between a renderer (master) and
// the frame scheduler (slave).
interface display_frame_scheduler_if;
  import display_frame_scheduler_pkg::*;

  logic       draw_valid;
  logic       draw_ready;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  pixel_t     draw_data;
  logic       draw_done;
  logic       frame_begin;

  modport master (
    output draw_valid,
    output draw_x,
    output draw_y,
    output draw_data,
    output draw_done,
    input  draw_ready,
    input  frame_begin
  );

  modport slave (
    input  draw_valid,
    input  draw_x,
    input  draw_y,
    input  draw_data,
    input  draw_done,
    output draw_ready,
    output frame_begin
  );

endinterface

// File: rtl/raster_counter.sv
// Raster-order x/y sweep counter: x inner, y outer, wraps to (0,0)
// after the last pixel.
module raster_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       last
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  always_ff @(posedge clock) begin
    if (!reset || start) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/display_frame_scheduler.sv
// Per-frame back-buffer sequencer: clear, draw, wait for vblank,
// swap. Owns the mux port-b write controls and the swap strobe.
module display_frame_scheduler
  import display_frame_scheduler_pkg::*;
#(
  parameter int H_ACTIVE     = DISPLAY_H_ACTIVE,
  parameter int V_ACTIVE     = DISPLAY_V_ACTIVE,
  parameter bit CLEAR_ENABLE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync_start,
  input  pixel_t      clear_color,
  display_frame_scheduler_if.slave draw,
  output logic [9:0]  buf_x,
  output logic [9:0]  buf_y,
  output logic        buf_we,
  output pixel_t      buf_wdata,
  output logic        frame_complete,
  output logic [15:0] frame_count,
  output logic [15:0] frames_dropped
);

  localparam frame_sched_state_t START_ST =
    CLEAR_ENABLE ? ST_CLEAR : ST_DRAW;
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  frame_sched_state_t state;
  frame_sched_state_t next_state;

  logic [9:0] clr_x;
  logic [9:0] clr_y;
  logic       clr_last;
  logic       handshake;
  logic       in_range;
  logic       drop;

  logic       we_d;
  logic [9:0] x_d;
  logic [9:0] y_d;
  pixel_t     wdata_d;
  logic       complete_d;
  logic       begin_d;
  logic       begin_q;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_clear_cnt (
    .clock   (clock),
    .reset   (reset),
    .start   (state != ST_CLEAR),
    .advance (state == ST_CLEAR),
    .x       (clr_x),
    .y       (clr_y),
    .last    (clr_last)
  );

  assign draw.draw_ready  = (state == ST_DRAW);
  assign draw.frame_begin = begin_q;

  assign handshake = draw.draw_valid && draw.draw_ready;
  assign in_range  = ({1'b0, draw.draw_x} < H_LIM) &&
                     ({1'b0, draw.draw_y} < V_LIM);

  always_ff @(posedge clock) begin
    if (!reset) state <= START_ST;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_CLEAR:
        if (clr_last) next_state = ST_DRAW;
      ST_DRAW:
        if (draw.draw_done)
          next_state = vsync_start ? ST_SWAP : ST_WAIT_VBLANK;
      ST_WAIT_VBLANK:
        if (vsync_start) next_state = ST_SWAP;
      ST_SWAP:
        next_state = START_ST;
      default:
        next_state = START_ST;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    x_d     = buf_x;
    y_d     = buf_y;
    wdata_d = buf_wdata;
    unique case (1'b1)
      (state == ST_CLEAR): begin
        we_d    = 1'b1;
        x_d     = clr_x;
        y_d     = clr_y;
        wdata_d = clear_color;
      end
      handshake: begin
        we_d    = in_range;
        x_d     = draw.draw_x;
        y_d     = draw.draw_y;
        wdata_d = draw.draw_data;
      end
      default: ;
    endcase
    complete_d = (next_state == ST_SWAP);
    begin_d    = (next_state == ST_DRAW) && (state != ST_DRAW);
    // A vblank is only useful in WAIT_VBLANK or alongside draw_done
    drop = vsync_start &&
           ((state == ST_CLEAR) || (state == ST_SWAP) ||
            ((state == ST_DRAW) && !draw.draw_done));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      buf_we         <= 1'b0;
      buf_x          <= '0;
      buf_y          <= '0;
      buf_wdata      <= '0;
      frame_complete <= 1'b0;
      begin_q        <= 1'b0;
      frame_count    <= '0;
      frames_dropped <= '0;
    end else begin
      buf_we         <= we_d;
      buf_x          <= x_d;
      buf_y          <= y_d;
      buf_wdata      <= wdata_d;
      frame_complete <= complete_d;
      begin_q        <= begin_d;
      frame_count    <= frame_count + {15'd0, complete_d};
      if (drop) frames_dropped <= sat_inc16(frames_dropped);
    end
  end

endmodule
